// File: rtl/comet_ii_mem_arbiter.sv
// comet_ii_mem_arbiter
// Shares one single-port memory between the COMET II core and an external
// master (loader/debug). One access at a time: IDLE arbitrates, ACCESS
// issues the strobe for exactly one cycle, and RWAIT counts out the fixed
// read latency before returning read data to the owner.
//
// Build option: define COMET_II_ARB_RR_EN for round-robin arbitration.
// Left undefined, the CPU has fixed priority and the external master is
// guaranteed a win after STARVE_MAX consecutive lost arbitrations.
module comet_ii_mem_arbiter #(
  parameter int RD_LAT     = 1,  // cycles from mem_en to valid mem_rdata (1..3)
  parameter int STARVE_MAX = 4   // ext losses before it is forced to win (1..15)
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [15:0] ext_adr,
  input  logic [15:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [15:0] ext_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_adr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RWAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LAT_INIT   = 2'(RD_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        owner_ext_q, owner_ext_d;   // 1: current access belongs to ext
  logic        we_q, we_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  lat_q, lat_d;               // read cycles still to wait
  logic [3:0]  starve_q, starve_d;         // consecutive ext losses
  logic        last_ext_q, last_ext_d;     // 1: ext won the last arbitration
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] ext_rdata_q, ext_rdata_d;
  logic        any_req;
  logic        ext_win;

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    any_req = cpu_req | ext_req;
`ifdef COMET_II_ARB_RR_EN
    // Tie goes to whichever master did not win last time.
    ext_win = ext_req & (~cpu_req | ~last_ext_q);
`else
    // CPU first, unless ext has already lost STARVE_MAX times in a row.
    ext_win = ext_req & (~cpu_req | (starve_q == STARVE_LIM));
`endif
  end

  // Next-state logic and access handshakes.
  always_comb begin
    state_d     = state_q;
    owner_ext_d = owner_ext_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    last_ext_d  = last_ext_q;
    cpu_gnt     = 1'b0;
    ext_gnt     = 1'b0;
    cpu_rvalid  = 1'b0;
    ext_rvalid  = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_ext_d = ext_win;
          last_ext_d  = ext_win;
          we_d        = ext_win ? ext_we    : cpu_we;
          adr_d       = ext_win ? ext_adr   : cpu_adr;
          wdata_d     = ext_win ? ext_wdata : cpu_wdata;
`ifndef COMET_II_ARB_RR_EN
          // Only a real loss (ext asking, CPU winning) counts as starvation.
          if (ext_win) begin
            starve_d = 4'd0;
          end else if (ext_req) begin
            starve_d = starve_q + 4'd1;
          end
`endif
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        cpu_gnt = ~owner_ext_q;
        ext_gnt = owner_ext_q;
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_RWAIT;
        end
      end

      S_RWAIT: begin
        // Counter value 1 marks the RD_LAT-th cycle after ACCESS.
        if (lat_q == 2'd1) begin
          cpu_rvalid = ~owner_ext_q;
          ext_rvalid = owner_ext_q;
          lat_d      = 2'd0;
          state_d    = S_IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Read data passes straight through on rvalid, otherwise holds.
    cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    ext_rdata_d = ext_rvalid ? mem_rdata : ext_rdata_q;
    cpu_rdata   = cpu_rdata_d;
    ext_rdata   = ext_rdata_d;
    mem_adr     = adr_q;
    mem_wdata   = wdata_q;
    busy        = (state_q != S_IDLE);
  end

  // State and datapath registers; reset drops any outstanding read.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_ext_q <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 16'd0;
      wdata_q     <= 16'd0;
      lat_q       <= 2'd0;
      starve_q    <= 4'd0;
      last_ext_q  <= 1'b1;
      cpu_rdata_q <= 16'd0;
      ext_rdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_ext_q <= owner_ext_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      last_ext_q  <= last_ext_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

endmodule

// File: tb/tb_comet_ii_mem_arbiter.sv
// tb_comet_ii_mem_arbiter
// Directed scenarios plus a randomized run checked against a cycle-level
// transaction model of the arbiter built from its arbitration rules.
`timescale 1ns/1ps
module tb_comet_ii_mem_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;
  localparam int NCYC       = 600;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_adr = 16'd0, cpu_wdata = 16'd0;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [15:0] ext_adr = 16'd0, ext_wdata = 16'd0;
  logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [15:0] cpu_rdata, ext_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_adr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  comet_ii_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .mclk(mclk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 mclk = ~mclk;

  // Memory environment: 256 words (address bits 7:0), fixed read latency.
  bit [15:0] env_mem [256];
  bit        env_wr  [256];
  bit [7:0]  rd_pipe [3];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h00) return 16'hBEEF;
    return {a ^ 8'h5A, ~a};
  endfunction

  always @(posedge mclk) begin
    if (mem_en && mem_we) begin
      env_mem[mem_adr[7:0]] <= mem_wdata;
      env_wr[mem_adr[7:0]]  <= 1'b1;
    end
    rd_pipe[0] <= mem_adr[7:0];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end

  assign mem_rdata = env_wr[rd_pipe[RD_LAT-1]] ? env_mem[rd_pipe[RD_LAT-1]]
                                               : init_val(rd_pipe[RD_LAT-1]);

  // Reference memory contents as the bench expects them to be.
  bit [15:0] ref_mem [256];
  bit        ref_wr  [256];

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : init_val(a[7:0]);
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a[7:0]] = d;
    ref_wr[a[7:0]]  = 1'b1;
  endtask

  function automatic logic [70:0] all_outs();
    return {cpu_gnt, cpu_rvalid, cpu_rdata, ext_gnt, ext_rvalid, ext_rdata,
            mem_en, mem_we, mem_adr, mem_wdata, busy};
  endfunction

  task automatic do_reset();
    @(negedge mclk);
    rst = 1'b0; cpu_req = 1'b0; ext_req = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (all_outs() !== 71'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0100; cpu_wdata = 16'h0000;
    @(negedge mclk);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL reset_pre_gnt: got %b want 1", cpu_gnt); end
    cpu_req = 1'b0;
    @(negedge mclk);
    rst = 1'b0;
    #1;
    checks++; if (all_outs() !== 71'd0) begin errors++; $display("FAIL reset_mid_rwait: got %h want 0", all_outs()); end
    @(negedge mclk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge mclk);
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_no_rvalid: got %b want 0", cpu_rvalid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0100; cpu_wdata = 16'h5555;
    @(negedge mclk);
    checks++; if (cpu_gnt !== 1'b1 || ext_gnt !== 1'b0) begin errors++; $display("FAIL read_gnt: cpu %b ext %b want 1 0", cpu_gnt, ext_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL read_strobe: en %b we %b want 1 0", mem_en, mem_we); end
    checks++; if (mem_adr !== 16'h0100) begin errors++; $display("FAIL read_adr: got %h want 0100", mem_adr); end
    cpu_req = 1'b0;
    @(negedge mclk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL read_early: rvalid got %b want 0", cpu_rvalid); end
    @(negedge mclk);
    checks++; if (cpu_rvalid !== 1'b1 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL read_rvalid: cpu %b ext %b want 1 0", cpu_rvalid, ext_rvalid); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h want beef", cpu_rdata); end
    @(negedge mclk);
    checks++; if (cpu_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_done: rvalid %b busy %b want 0 0", cpu_rvalid, busy); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_hold: got %h want beef", cpu_rdata); end
  endtask

  task automatic test_cpu_write();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0200; cpu_wdata = 16'h1234;
    @(negedge mclk);
    ref_write(16'h0200, 16'h1234);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL write_gnt: got %b want 1", cpu_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL write_strobe: en %b we %b want 1 1", mem_en, mem_we); end
    checks++; if (mem_adr !== 16'h0200 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL write_bus: adr %h data %h want 0200 1234", mem_adr, mem_wdata); end
    cpu_req = 1'b0;
    @(negedge mclk);
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_done: en %b we %b busy %b want 0 0 0", mem_en, mem_we, busy); end
    checks++; if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL write_pulse: rvalid %b gnt %b want 0 0", cpu_rvalid, cpu_gnt); end
    checks++; if (mem_adr !== 16'h0200) begin errors++; $display("FAIL write_adr_hold: got %h want 0200", mem_adr); end
  endtask

  task automatic test_arbitration();
    int k, cyc, last_cyc;
    logic want_ext;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0311; cpu_wdata = 16'hC000;
    ext_req = 1'b1; ext_we = 1'b1; ext_adr = 16'h0422; ext_wdata = 16'hE000;
    k = 0; cyc = 0; last_cyc = 0;
    while (k < 10 && cyc < 60) begin
      @(negedge mclk);
      cyc++;
      checks++; if (cpu_gnt && ext_gnt) begin errors++; $display("FAIL arb_one_winner: cpu %b ext %b", cpu_gnt, ext_gnt); end
      if (cpu_gnt || ext_gnt) begin
`ifdef COMET_II_ARB_RR_EN
        want_ext = (k % 2) == 1;
`else
        want_ext = (k % (STARVE_MAX + 1)) == STARVE_MAX;
`endif
        checks++; if (ext_gnt !== want_ext) begin errors++; $display("FAIL arb_order[%0d]: ext_gnt got %b want %b", k, ext_gnt, want_ext); end
        if (k > 0) begin
          checks++; if (cyc - last_cyc != 2) begin errors++; $display("FAIL arb_spacing[%0d]: got %0d want 2", k, cyc - last_cyc); end
        end
        if (ext_gnt) begin
          ref_write(ext_adr, ext_wdata); ext_wdata = ext_wdata + 16'd1;
        end else begin
          ref_write(cpu_adr, cpu_wdata); cpu_wdata = cpu_wdata + 16'd1;
        end
        last_cyc = cyc;
        k++;
      end
    end
    checks++; if (k != 10) begin errors++; $display("FAIL arb_timeout: grants %0d want 10", k); end
    cpu_req = 1'b0; ext_req = 1'b0;
  endtask

  task automatic test_withdraw();
    int ncpu, cyc, want_ncpu;
    logic seen_ext;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0105;
    @(negedge mclk);
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_adr = 16'h0433; ext_wdata = 16'hDEAD;
    @(negedge mclk);
    ext_req = 1'b0;
    repeat (6) begin
      checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL withdraw_gnt: got %b want 0", ext_gnt); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL withdraw_access: mem_en got %b want 0", mem_en); end
      @(negedge mclk);
    end
    // Starvation state must be untouched: both masters now ask continuously.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0344; cpu_wdata = 16'hA000;
    ext_req = 1'b1;
    ncpu = 0; cyc = 0; seen_ext = 1'b0;
    while (!seen_ext && cyc < 40) begin
      @(negedge mclk);
      cyc++;
      if (cpu_gnt) begin ncpu++; ref_write(cpu_adr, cpu_wdata); end
      if (ext_gnt) begin seen_ext = 1'b1; ref_write(ext_adr, ext_wdata); end
    end
`ifdef COMET_II_ARB_RR_EN
    want_ncpu = 0;
`else
    want_ncpu = STARVE_MAX;
`endif
    checks++; if (!seen_ext || ncpu != want_ncpu) begin errors++; $display("FAIL withdraw_counter: cpu grants before ext %0d (ext seen %b) want %0d", ncpu, seen_ext, want_ncpu); end
    cpu_req = 1'b0; ext_req = 1'b0;
  endtask

  task automatic test_random();
    logic        e_cgnt [NCYC+8];
    logic        e_egnt [NCYC+8];
    logic        e_en   [NCYC+8];
    logic        e_we   [NCYC+8];
    logic [15:0] e_adr  [NCYC+8];
    logic [15:0] e_wd   [NCYC+8];
    logic        e_crv  [NCYC+8];
    logic        e_erv  [NCYC+8];
    logic [15:0] e_rd   [NCYC+8];
    logic        e_busy [NCYC+8];
    int          free_at, starve;
    logic        last_ext, w_ext, w_we;
    logic [15:0] w_adr, w_wd, cur_adr, cur_wd, cpu_exp, ext_exp;
    for (int i = 0; i < NCYC + 8; i++) begin
      e_cgnt[i] = 0; e_egnt[i] = 0; e_en[i] = 0; e_we[i] = 0; e_adr[i] = 0;
      e_wd[i] = 0; e_crv[i] = 0; e_erv[i] = 0; e_rd[i] = 0; e_busy[i] = 0;
    end
    do_reset();
    free_at = 0; starve = 0; last_ext = 1'b1;
    cur_adr = 16'd0; cur_wd = 16'd0; cpu_exp = 16'd0; ext_exp = 16'd0;
    for (int c = 0; c < NCYC; c++) begin
      if (e_en[c]) begin cur_adr = e_adr[c]; cur_wd = e_wd[c]; end
      if (e_crv[c]) cpu_exp = e_rd[c];
      if (e_erv[c]) ext_exp = e_rd[c];
      checks++; if (cpu_gnt !== e_cgnt[c]) begin errors++; $display("FAIL rnd_cpu_gnt@%0d: got %b want %b", c, cpu_gnt, e_cgnt[c]); end
      checks++; if (ext_gnt !== e_egnt[c]) begin errors++; $display("FAIL rnd_ext_gnt@%0d: got %b want %b", c, ext_gnt, e_egnt[c]); end
      checks++; if (mem_en !== e_en[c]) begin errors++; $display("FAIL rnd_mem_en@%0d: got %b want %b", c, mem_en, e_en[c]); end
      checks++; if (mem_we !== (e_en[c] & e_we[c])) begin errors++; $display("FAIL rnd_mem_we@%0d: got %b want %b", c, mem_we, e_en[c] & e_we[c]); end
      checks++; if (mem_adr !== cur_adr) begin errors++; $display("FAIL rnd_mem_adr@%0d: got %h want %h", c, mem_adr, cur_adr); end
      checks++; if (mem_wdata !== cur_wd) begin errors++; $display("FAIL rnd_mem_wdata@%0d: got %h want %h", c, mem_wdata, cur_wd); end
      checks++; if (cpu_rvalid !== e_crv[c]) begin errors++; $display("FAIL rnd_cpu_rvalid@%0d: got %b want %b", c, cpu_rvalid, e_crv[c]); end
      checks++; if (ext_rvalid !== e_erv[c]) begin errors++; $display("FAIL rnd_ext_rvalid@%0d: got %b want %b", c, ext_rvalid, e_erv[c]); end
      checks++; if (cpu_rdata !== cpu_exp) begin errors++; $display("FAIL rnd_cpu_rdata@%0d: got %h want %h", c, cpu_rdata, cpu_exp); end
      checks++; if (ext_rdata !== ext_exp) begin errors++; $display("FAIL rnd_ext_rdata@%0d: got %h want %h", c, ext_rdata, ext_exp); end
      checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, e_busy[c]); end

      // Masters: a granted request completes; idle masters may start a new one.
      if (e_cgnt[c]) cpu_req = 1'b0;
      if (e_egnt[c]) ext_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) != 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_adr = 16'($urandom); cpu_wdata = 16'($urandom);
      end
      if (ext_req && $urandom_range(0, 15) == 0) begin
        ext_req = 1'b0;
      end else if (!ext_req && $urandom_range(0, 2) != 0) begin
        ext_req = 1'b1; ext_we = 1'($urandom_range(0, 1));
        ext_adr = 16'($urandom); ext_wdata = 16'($urandom);
      end

      // Model: arbitration happens whenever the arbiter is free and someone asks.
      if (c >= free_at && (cpu_req || ext_req)) begin
`ifdef COMET_II_ARB_RR_EN
        w_ext = ext_req && (!cpu_req || !last_ext);
`else
        if (ext_req && cpu_req) w_ext = (starve == STARVE_MAX);
        else                    w_ext = ext_req;
        if (w_ext)        starve = 0;
        else if (ext_req) starve = starve + 1;
`endif
        last_ext = w_ext;
        w_we  = w_ext ? ext_we    : cpu_we;
        w_adr = w_ext ? ext_adr   : cpu_adr;
        w_wd  = w_ext ? ext_wdata : cpu_wdata;
        e_cgnt[c+1] = !w_ext; e_egnt[c+1] = w_ext;
        e_en[c+1] = 1'b1; e_we[c+1] = w_we; e_adr[c+1] = w_adr; e_wd[c+1] = w_wd;
        e_busy[c+1] = 1'b1;
        if (w_we) begin
          ref_write(w_adr, w_wd);
          free_at = c + 2;
        end else begin
          for (int j = 2; j <= RD_LAT + 1; j++) e_busy[c+j] = 1'b1;
          if (w_ext) e_erv[c+1+RD_LAT] = 1'b1;
          else       e_crv[c+1+RD_LAT] = 1'b1;
          e_rd[c+1+RD_LAT] = ref_read(w_adr);
          free_at = c + RD_LAT + 2;
        end
      end
      @(negedge mclk);
    end
    cpu_req = 1'b0; ext_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_arbitration();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
